// File: rtl/lcd_host_if.sv
// Signal bundle between lcd_host and its surroundings: image write port, op handshake,
// display-controller link and result-buffer read port.
interface lcd_host_if;
    logic       img_we;
    logic [5:0] img_addr;
    logic [7:0] img_wdata;

    logic       op_valid;
    logic [2:0] op_cmd;
    logic       op_ready;

    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic       lcd_busy;
    logic       lcd_output_valid;
    logic [7:0] lcd_dataout;

    logic [3:0] res_addr;
    logic [7:0] res_rdata;
    logic       res_done;
    logic       err_timeout;

    modport slave (
        input  img_we, img_addr, img_wdata, op_valid, op_cmd,
               lcd_busy, lcd_output_valid, lcd_dataout, res_addr,
        output op_ready, lcd_cmd, lcd_cmd_valid, lcd_datain,
               res_rdata, res_done, err_timeout
    );

    modport master (
        output img_we, img_addr, img_wdata, op_valid, op_cmd,
               lcd_busy, lcd_output_valid, lcd_dataout, res_addr,
        input  op_ready, lcd_cmd, lcd_cmd_valid, lcd_datain,
               res_rdata, res_done, err_timeout
    );
endinterface

// File: rtl/lcd_host.sv
// Host sequencer for an LCD controller: issues one command per op, streams the 8x8 image
// on load, then captures a 16-pixel result window with a no-response timeout.
module lcd_host (
    input  logic      clk,
    input  logic      reset,
    lcd_host_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, ISSUE, STREAM, CAPTURE, FINISH
    } state_e;

    localparam logic [2:0] CMD_LOAD = 3'd1;

    state_e     state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    logic [5:0] kcnt_q, kcnt_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       full_q, full_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       err_q, err_d;
    logic       capture;

    logic [7:0] img_mem [64];
    logic [7:0] res_mem [16];

    // full_q guards against wcnt wrapping if all 16 pixels arrive while still streaming.
    assign capture = !reset && bus.lcd_output_valid && !full_q &&
                     (state_q == STREAM || state_q == CAPTURE);

    // NOTE: both memories are deliberately left out of reset; their contents must survive it.
    always_ff @(posedge clk) begin
        if (bus.img_we) img_mem[bus.img_addr] <= bus.img_wdata;
        if (capture)    res_mem[wcnt_q]       <= bus.lcd_dataout;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            kcnt_q  <= '0;
            wcnt_q  <= '0;
            full_q  <= 1'b0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            kcnt_q  <= kcnt_d;
            wcnt_q  <= wcnt_d;
            full_q  <= full_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        kcnt_d  = kcnt_q;
        wcnt_d  = wcnt_q;
        full_d  = full_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;

        if (capture) begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == 4'd15) full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    cmd_d   = bus.op_cmd;
                    wcnt_d  = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!bus.lcd_busy) state_d = ISSUE;
            end
            ISSUE: begin
                kcnt_d  = '0;
                tcnt_d  = '0;
                state_d = (cmd_q == CMD_LOAD) ? STREAM : CAPTURE;
            end
            STREAM: begin
                kcnt_d = kcnt_q + 6'd1;
                tcnt_d = '0;
                if (kcnt_q == 6'd63) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (full_d) begin
                    state_d = FINISH;
                end else if (!bus.lcd_output_valid) begin
                    // The 255th idle capture cycle aborts the op without a done pulse.
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_q == 8'd254) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.op_ready      = (state_q == IDLE);
    assign bus.lcd_cmd_valid = (state_q == ISSUE);
    assign bus.lcd_cmd       = (state_q == ISSUE) ? cmd_q : 3'd0;
    assign bus.res_done      = (state_q == FINISH);
    assign bus.err_timeout   = err_q;
    assign bus.res_rdata     = res_mem[bus.res_addr];

    always_comb begin
        bus.lcd_datain = '0;
        if (state_q == ISSUE && cmd_q == CMD_LOAD) begin
            bus.lcd_datain = img_mem[0];
        end else if (state_q == STREAM) begin
            bus.lcd_datain = img_mem[kcnt_q];
        end
    end
endmodule

// File: tb/tb_lcd_host.sv
// Randomized self-checking bench for lcd_host; expected timing and data come from a
// cycle-count model of the op sequence plus reference copies of both memories.
module tb_lcd_host;
    logic clk = 1'b0;
    logic reset;

    lcd_host_if bus ();

    lcd_host dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] img_ref [64];
    logic [7:0] exp_res [16];
    logic       err_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_img(input int a, input logic [7:0] d);
        bus.img_we    = 1'b1;
        bus.img_addr  = 6'(a);
        bus.img_wdata = d;
        img_ref[a]    = d;
        tick();
        bus.img_we    = 1'b0;
    endtask

    task automatic check_res();
        for (int i = 0; i < 16; i++) begin
            bus.res_addr = 4'(i);
            tick();
            check($sformatf("res[%0d]", i), 32'(bus.res_rdata), 32'(exp_res[i]));
        end
    endtask

    // One op from acceptance to return to IDLE. Expected cycle n is counted from the
    // sample point where op_valid is first presented (n=0). rst_k >= 0 pulses reset on
    // stream beat rst_k; respond=0 models a controller that never answers.
    task automatic do_op(input logic [2:0] cmd, input int busy_cyc, input bit respond,
                         input bit hold, input int rst_k, input bit wr_stream,
                         input bit fixed_pix);
        logic [7:0] pix [16];
        bit         load;
        bit         aborted;
        int         n_issue, n_cap, strobe_start, n_rst;
        int         px, last, cv_cycles, issue_at, done_cnt, done_at, a;

        load         = (cmd == 3'd1);
        n_issue      = busy_cyc + 2;
        n_cap        = load ? n_issue + 65 : n_issue + 1;
        strobe_start = load ? n_issue + 61 : n_issue + 1;
        n_rst        = (rst_k >= 0) ? n_issue + 1 + rst_k : -10;
        px = 0; last = -10; cv_cycles = 0; issue_at = -1; done_cnt = 0; done_at = -1;
        aborted = 1'b0;
        for (int i = 0; i < 16; i++)
            pix[i] = fixed_pix ? 8'((i / 4) * 8 + (i % 4)) : 8'($urandom);

        check("ready_idle", 32'(bus.op_ready), 32'd1);
        check("err_sticky", 32'(bus.err_timeout), 32'(err_exp));
        bus.op_valid         = 1'b1;
        bus.op_cmd           = cmd;
        bus.lcd_busy         = (busy_cyc > 0);
        bus.lcd_output_valid = 1'b0;

        for (int n = 1; n < 2000; n++) begin
            tick();
            if (bus.lcd_cmd_valid) begin
                cv_cycles++;
                if (issue_at < 0) issue_at = n;
            end
            if (bus.res_done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n == 1) begin
                check("accepted", 32'(bus.op_ready), 32'd0);
                check("err_clr", 32'(bus.err_timeout), 32'd0);
                err_exp = 1'b0;
            end
            if (n == n_rst + 1) begin
                check("rst_ready", 32'(bus.op_ready), 32'd1);
                check("rst_datain", 32'(bus.lcd_datain), 32'd0);
                check("rst_cmd_valid", 32'(bus.lcd_cmd_valid), 32'd0);
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (n == n_issue) begin
                check("issue_cmd", 32'(bus.lcd_cmd), 32'(cmd));
                check("issue_datain", 32'(bus.lcd_datain), 32'(load ? img_ref[0] : 8'd0));
            end
            if (load && n > n_issue && n <= n_issue + 64)
                check($sformatf("stream[%0d]", n - n_issue - 1), 32'(bus.lcd_datain),
                      32'(img_ref[n - n_issue - 1]));
            if (respond && px == 16 && n == last + 2) begin
                check("ready_after", 32'(bus.op_ready), 32'd1);
                break;
            end
            if (!respond && n == n_cap + 254) begin
                check("to_err_early", 32'(bus.err_timeout), 32'd0);
                check("to_ready_early", 32'(bus.op_ready), 32'd0);
            end
            if (!respond && n == n_cap + 255) begin
                check("to_err", 32'(bus.err_timeout), 32'd1);
                check("to_ready", 32'(bus.op_ready), 32'd1);
                err_exp = 1'b1;
                break;
            end

            bus.op_valid = hold;
            bus.lcd_busy = (n <= busy_cyc);
            bus.img_we   = 1'b0;
            if (wr_stream && load && n > n_issue && n <= n_issue + 64 &&
                $urandom_range(2, 0) == 0) begin
                a             = int'($urandom_range(63, 0));
                bus.img_we    = 1'b1;
                bus.img_addr  = 6'(a);
                bus.img_wdata = 8'($urandom);
                img_ref[a]    = bus.img_wdata;
            end
            bus.lcd_output_valid = 1'b0;
            bus.lcd_dataout      = 8'($urandom);
            if (n <= n_issue) begin
                // Junk strobes before any capture window must be ignored.
                bus.lcd_output_valid = ($urandom_range(1, 0) == 1);
            end else if (respond && px < 16 && n >= strobe_start &&
                         $urandom_range(1, 0) == 1) begin
                bus.lcd_output_valid = 1'b1;
                bus.lcd_dataout      = pix[px];
                px++;
                last = n;
            end
            if (n == n_rst) reset = 1'b1;
        end

        bus.op_valid         = hold;
        bus.lcd_output_valid = 1'b0;
        bus.img_we           = 1'b0;
        bus.lcd_busy         = 1'b0;
        check("issue_at", 32'(issue_at), 32'(n_issue));
        check("cmd_valid_cycles", 32'(cv_cycles), 32'd1);
        check("done_count", 32'(done_cnt), (respond && !aborted) ? 32'd1 : 32'd0);
        if (respond && !aborted) begin
            check("done_at", 32'(done_at), 32'(last + 1));
            for (int i = 0; i < 16; i++) exp_res[i] = pix[i];
        end
    endtask

    initial begin
        reset                = 1'b1;
        bus.img_we           = 1'b0;
        bus.img_addr         = '0;
        bus.img_wdata        = '0;
        bus.op_valid         = 1'b0;
        bus.op_cmd           = '0;
        bus.lcd_busy         = 1'b0;
        bus.lcd_output_valid = 1'b0;
        bus.lcd_dataout      = '0;
        bus.res_addr         = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check("rst_cmd_valid", 32'(bus.lcd_cmd_valid), 32'd0);
        check("rst_lcd_cmd", 32'(bus.lcd_cmd), 32'd0);
        check("rst_datain", 32'(bus.lcd_datain), 32'd0);
        check("rst_res_done", 32'(bus.res_done), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);

        for (int i = 0; i < 64; i++) write_img(i, 8'(i));

        do_op(3'd1, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);   // load, image[i]=i
        check_res();
        do_op(3'd0, 0, 1'b1, 1'b0, -1, 1'b0, 1'b1);   // refresh, 4x4 window pattern
        check_res();
        do_op(3'd2, 20, 1'b1, 1'b0, -1, 1'b0, 1'b0);  // busy held for 20 cycles
        check_res();
        do_op(3'd1, 3, 1'b1, 1'b0, -1, 1'b1, 1'b0);   // image writes during stream
        check_res();

        do_op(3'd4, 1, 1'b0, 1'b0, -1, 1'b0, 1'b0);   // controller never answers
        check_res();
        do_op(3'd3, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);   // clears the sticky timeout

        for (int i = 0; i < 64; i++) write_img(i, 8'(i));
        do_op(3'd1, 0, 1'b1, 1'b0, 30, 1'b0, 1'b0);   // reset on stream beat 30
        check_res();
        do_op(3'd1, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);   // image survives reset

        do_op(3'd5, 2, 1'b1, 1'b1, -1, 1'b0, 1'b0);   // op_valid held high throughout
        do_op(3'd6, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        do_op(3'd7, 1, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        check_res();

        for (int r = 0; r < 6; r++) begin
            do_op(3'($urandom_range(7, 0)), int'($urandom_range(5, 0)), 1'b1, 1'b0, -1,
                  1'($urandom_range(1, 0)), 1'b0);
            check_res();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
